conv3x3_stream_top: RTL and testbench
=====================================

// Module: conv3x3_stream_top
// PURPOSE
//  Streaming 3x3 "valid" 2-D convolution engine for the CNN datapath. Accepts one pixel per enabled
//  cycle, raster order. Holds two line buffers of IMG_W pixels and a 3x3 window.
//  Emits one result per complete window, with frame/line framing flags.
//  Frames inside a dim group (frame_start_dim_in .. frame_end_dim_in) use successive kernel channels.
// PARAMETERS
//  DATA_W  16   input pixel width, unsigned
//  IMG_W   32   pixels per input line
//  N_CH    5    kernel channels (frames per dim group)
//  W_W     8    signed weight width
//  ACC_W   32   signed result width
//  KERNEL  -    N_CH*9*W_W packed weights [c][ky][kx], index 0 = top-left
//               default: every weight of channel c = c+1
// PORTS
//  clk                 in   1       single clock, rising edge
//  rst_n               in   1       asynchronous, active-high reset (asserted = 1; name kept per codebase)
//  ima                 in   DATA_W  input pixel
//  ena_in              in   1       pixel valid; ima and line/end flags are sampled only when 1
//  frame_start_in      in   1       start of frame (driven with ena_in=0 the cycle before pixel 0)
//  frame_start_dim_in  in   1       with frame_start_in: first frame of dim group
//  line_start_in       in   1       with ena_in: this pixel is last of its line (not last line)
//  frame_end_in        in   1       with ena_in: this pixel is last of frame
//  frame_end_dim_in    in   1       with frame_end_in: last frame of dim group
//  conv_out            out  ACC_W   convolution result
//  out_valid           out  1       conv_out valid
//  frame_start_out     out  1       with first valid output of a frame
//  line_start_out      out  1       with last output of each output line except the last
//  frame_end_out       out  1       with last output of frame
// BEHAVIOUR
//  - Reset: all outputs 0. Row/col counters, channel index, pipeline valid bits and in_frame cleared.
//    Line-buffer contents need no reset.
//  - frame_start_in=1: col=row=0, in_frame=1, first_out pending. Pixels in flight still drain.
//    If frame_start_dim_in=1 also, channel index ch=0.
//  - Accepted pixel = ena_in & in_frame; pixels outside a frame are ignored. ena_in=0 stalls;
//    no counters move.
//  - Per accepted pixel: write it to the line buffers and shift the window.
//    Column wrap (col=0, row++) when col==IMG_W-1 or line_start_in=1; otherwise col++.
//  - Window complete when row>=2 && col>=2. Result is the sum over ky,kx of
//    KERNEL[ch][ky][kx]*P[row-2+ky][col-2+kx], signed ACC_W, pixel zero-extended.
//    No saturation needed at the defaults.
//  - Latency: fixed 2 cycles, pipelined, 1 result/cycle.
//    Cycle t: accept. t+1: product register. t+2: out_valid=1 with conv_out.
//  - Flags travel with the pixel through the pipeline, gated by window-complete:
//    line_start_out = line_start_in of that pixel; frame_end_out = frame_end_in of that pixel.
//    frame_start_out on the first valid output after frame_start_in.
//    A flag on a pixel that produces no output is dropped.
//  - frame_end_in accepted: in_frame=0. ch then increments, or wraps to 0 if frame_end_dim_in=1
//    or ch==N_CH-1. The output pipeline still completes.
//  - Simultaneous line_start_in and frame_end_in: frame end wins (no line_start_out).
//  - Reset mid-frame: everything aborts; no further output until the next frame_start_in.
//  - Nominal frame 35x32 -> 33 lines x 30 outputs = 990 outputs per frame.
// TESTING
//  1. Reset, then frame_start(+dim), frame ima=32*i+j (35x32), ch0 ->
//     first output 297 with frame_start_out; then 306, 315, ...; 990 outputs.
//  2. Same frame -> line_start_out on outputs 30, 60, ... (32 times);
//     frame_end_out only on output 990 = 9*(32*32+29+33) = 9774.
//  3. Five back-to-back frames, dim flags on 1st/5th ->
//     frame k first output = 297*(k+1); ch back to 0 after 5th.
//  4. Drop ena_in for 3 cycles mid-line -> output stream stalls; values are identical to test 1;
//     latency stays 2 cycles after resume.
//  5. Pixels with ena_in=1 before any frame_start_in -> out_valid stays 0.
//  6. Assert reset at row 10 -> all outputs 0 immediately; next frame produces the test-1 results exactly.

Source files
------------

// File: rtl/conv3x3_stream_top.sv
// Streaming 3x3 "valid" convolution: two line buffers feed a 3x3 window,
// then a registered product stage and a registered adder/output stage.

module conv3x3_stream_top #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 32,
    parameter int N_CH   = 5,
    parameter int W_W    = 8,
    parameter int ACC_W  = 32,
    // Default is sized for N_CH=5: every weight of channel c equals c+1
    parameter logic [N_CH*9*W_W-1:0] KERNEL = {{9{W_W'(5)}}, {9{W_W'(4)}}, {9{W_W'(3)}},
                                               {9{W_W'(2)}}, {9{W_W'(1)}}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        ima,
    input  logic                     ena_in,
    input  logic                     frame_start_in,
    input  logic                     frame_start_dim_in,
    input  logic                     line_start_in,
    input  logic                     frame_end_in,
    input  logic                     frame_end_dim_in,
    output logic signed [ACC_W-1:0]  conv_out,
    output logic                     out_valid,
    output logic                     frame_start_out,
    output logic                     line_start_out,
    output logic                     frame_end_out
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [COL_W-1:0]        col;
    logic [1:0]              row;
    logic [CH_W-1:0]         ch;
    logic                    in_frame;
    logic                    first_pending;
    logic                    accept;
    logic                    win_ok;
    logic                    col_wrap;

    logic [DATA_W-1:0]       lb0 [IMG_W];
    logic [DATA_W-1:0]       lb1 [IMG_W];
    logic [DATA_W-1:0]       win [3][3];
    logic [DATA_W-1:0]       nxt_win [3][3];
    logic signed [ACC_W-1:0] prod_d [9];
    logic signed [ACC_W-1:0] prod_q [9];
    logic signed [ACC_W-1:0] sum;

    logic                    s1_valid;
    logic                    s1_fstart;
    logic                    s1_line;
    logic                    s1_fend;

    // Row only needs to saturate at 2: that is all the window-complete test looks at
    assign accept   = ena_in & in_frame & ~frame_start_in;
    assign win_ok   = (row == 2'd2) && (col >= COL_W'(2));
    assign col_wrap = (col == COL_W'(IMG_W - 1)) | line_start_in;

    always_comb begin
        for (int ky = 0; ky < 3; ky++) begin
            nxt_win[ky][0] = win[ky][1];
            nxt_win[ky][1] = win[ky][2];
        end
        nxt_win[0][2] = lb1[col];
        nxt_win[1][2] = lb0[col];
        nxt_win[2][2] = ima;
    end

    always_comb begin
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                prod_d[ky*3+kx] = ACC_W'($signed({1'b0, nxt_win[ky][kx]}))
                                * ACC_W'($signed(KERNEL[(int'(ch)*9 + ky*3 + kx)*W_W +: W_W]));
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + prod_q[k];
        end
    end

    // Pixel storage carries no reset; validity is tracked by the control pipeline
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= ima;
            win      <= nxt_win;
            prod_q   <= prod_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            col             <= '0;
            row             <= '0;
            ch              <= '0;
            in_frame        <= 1'b0;
            first_pending   <= 1'b0;
            s1_valid        <= 1'b0;
            s1_fstart       <= 1'b0;
            s1_line         <= 1'b0;
            s1_fend         <= 1'b0;
            out_valid       <= 1'b0;
            frame_start_out <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
            conv_out        <= '0;
        end else begin
            if (frame_start_in) begin
                col           <= '0;
                row           <= '0;
                in_frame      <= 1'b1;
                first_pending <= 1'b1;
                if (frame_start_dim_in) begin
                    ch <= '0;
                end
            end else if (accept) begin
                if (frame_end_in) begin
                    in_frame <= 1'b0;
                    ch <= (frame_end_dim_in || ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
                end
                if (col_wrap) begin
                    col <= '0;
                    if (row != 2'd2) begin
                        row <= row + 2'd1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
                if (win_ok) begin
                    first_pending <= 1'b0;
                end
            end

            // A frame end on the same pixel suppresses its line flag
            s1_valid  <= accept & win_ok;
            s1_fstart <= accept & win_ok & first_pending;
            s1_line   <= accept & win_ok & line_start_in & ~frame_end_in;
            s1_fend   <= accept & win_ok & frame_end_in;

            out_valid       <= s1_valid;
            frame_start_out <= s1_fstart;
            line_start_out  <= s1_line;
            frame_end_out   <= s1_fend;
            conv_out        <= s1_valid ? sum : '0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_top.sv
// Directed bench for conv3x3_stream_top: frames of ima=32*i+j are driven and every
// output is compared against a queued expectation (value, flags, latency).

module tb_conv3x3_stream_top;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int IMG_W  = 32;
    localparam int N_ROWS = 35;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DATA_W-1:0]       ima;
    logic                    ena_in;
    logic                    frame_start_in;
    logic                    frame_start_dim_in;
    logic                    line_start_in;
    logic                    frame_end_in;
    logic                    frame_end_dim_in;
    logic signed [ACC_W-1:0] conv_out;
    logic                    out_valid;
    logic                    frame_start_out;
    logic                    line_start_out;
    logic                    frame_end_out;

    typedef struct {
        logic signed [63:0] value;
        logic               fs;
        logic               ls;
        logic               fe;
        int                 cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_lines  = 0;
    int   n_fs     = 0;
    int   n_fe     = 0;

    conv3x3_stream_top dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ima                (ima),
        .ena_in             (ena_in),
        .frame_start_in     (frame_start_in),
        .frame_start_dim_in (frame_start_dim_in),
        .line_start_in      (line_start_in),
        .frame_end_in       (frame_end_in),
        .frame_end_dim_in   (frame_end_dim_in),
        .conv_out           (conv_out),
        .out_valid          (out_valid),
        .frame_start_out    (frame_start_out),
        .line_start_out     (line_start_out),
        .frame_end_out      (frame_end_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] pix(input int i, input int j);
        return DATA_W'(32 * i + j);
    endfunction

    // Reference: direct 3x3 sum of the raster image with a uniform channel weight
    function automatic logic signed [63:0] model(input int r, input int c, input int wt);
        longint s = 0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                s += longint'(wt) * longint'(pix(r - 2 + ky, c - 2 + kx));
            end
        end
        return 64'(s);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [DATA_W-1:0] px,
                                 input logic fs, input logic fsd, input logic ls,
                                 input logic fe, input logic fed);
        @(negedge clk);
        ena_in             = en;
        ima                = px;
        frame_start_in     = fs;
        frame_start_dim_in = fsd;
        line_start_in      = ls;
        frame_end_in       = fe;
        frame_end_dim_in   = fed;
    endtask

    // One frame; optional 3-cycle stall before pixel index stall_at, optional abort at stop_row
    task automatic run_frame(input int wt, input bit dim_s, input bit dim_e,
                             input int stall_at, input int stop_row);
        bit   first = 1'b1;
        bit   last;
        exp_t e;
        applyStimulus(1'b0, '0, 1'b1, dim_s, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N_ROWS; i++) begin
            if (i == stop_row) return;
            for (int j = 0; j < IMG_W; j++) begin
                if (i * IMG_W + j == stall_at) begin
                    repeat (3) applyStimulus(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                end
                last = (i == N_ROWS - 1) && (j == IMG_W - 1);
                applyStimulus(1'b1, pix(i, j), 1'b0, 1'b0, j == IMG_W - 1, last, last & dim_e);
                if (i >= 2 && j >= 2) begin
                    e.value = model(i, j, wt);
                    e.fs    = first;
                    e.ls    = (j == IMG_W - 1) && !last;
                    e.fe    = last;
                    e.cyc   = cyc;
                    sb.push_back(e);
                    first = 1'b0;
                end
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 16 && sb.size() != 0; k++) @(negedge clk);
        #1;
        checkOutput(tag, sb.size(), 0);
    endtask

    task automatic zero_counts();
        n_valid = 0;
        n_lines = 0;
        n_fs    = 0;
        n_fe    = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_conv"}, conv_out, 0);
        checkOutput({tag, "_fs"}, frame_start_out, 0);
        checkOutput({tag, "_ls"}, line_start_out, 0);
        checkOutput({tag, "_fe"}, frame_end_out, 0);
    endtask

    task automatic check_frame_counts(input string tag, input int frames);
        checkOutput({tag, "_outputs"}, n_valid, 990 * frames);
        checkOutput({tag, "_line_flags"}, n_lines, 32 * frames);
        checkOutput({tag, "_start_flags"}, n_fs, frames);
        checkOutput({tag, "_end_flags"}, n_fe, frames);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b0 && out_valid !== 1'b0) begin
            n_valid++;
            if (line_start_out === 1'b1) n_lines++;
            if (frame_start_out === 1'b1) n_fs++;
            if (frame_end_out === 1'b1) n_fe++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", out_valid, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("conv_out", conv_out, e.value);
                checkOutput("frame_start_out", frame_start_out, e.fs);
                checkOutput("line_start_out", line_start_out, e.ls);
                checkOutput("frame_end_out", frame_end_out, e.fe);
                checkOutput("latency", cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: time limit reached with %0d expected outputs pending, required 0", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ena_in = 1'b0;
        ima = '0;
        frame_start_in = 1'b0;
        frame_start_dim_in = 1'b0;
        line_start_in = 1'b0;
        frame_end_in = 1'b0;
        frame_end_dim_in = 1'b0;
        #2 rst_n = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        $display("[TB] pixels before any frame start");
        zero_counts();
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, pix(2, k), 1'b0, 1'b0, k == 5, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("no_frame_outputs", n_valid, 0);

        $display("[TB] single frame, channel 0");
        zero_counts();
        run_frame(1, 1'b1, 1'b0, -1, -1);
        wait_drain("t1_drain");
        check_frame_counts("t1", 1);

        zero_counts();
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, pix(3, k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_frame_outputs", n_valid, 0);

        $display("[TB] dim group of five frames, then a plain frame");
        zero_counts();
        for (int k = 0; k < 5; k++) run_frame(k + 1, k == 0, k == 4, -1, -1);
        run_frame(1, 1'b0, 1'b0, -1, -1);
        wait_drain("t3_drain");
        check_frame_counts("t3", 6);

        $display("[TB] frame with a 3-cycle input stall");
        zero_counts();
        run_frame(1, 1'b1, 1'b1, 5 * IMG_W + 10, -1);
        wait_drain("t4_drain");
        check_frame_counts("t4", 1);

        $display("[TB] reset in the middle of a channel-1 frame");
        run_frame(1, 1'b1, 1'b0, -1, -1);
        run_frame(2, 1'b0, 1'b0, -1, 10);
        #1 rst_n = 1'b1;
        #1 check_outputs_zero("midreset");
        sb.delete();
        repeat (3) applyStimulus(1'b1, pix(10, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        zero_counts();
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, pix(10, k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_reset_outputs", n_valid, 0);
        run_frame(1, 1'b0, 1'b0, -1, -1);
        wait_drain("t6_drain");
        check_frame_counts("t6", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
